// File: rtl/background_data_sequencer.sv
// Avalon-MM slave that queues background tile words and drains them into tile memory
// during vertical blanking via a valid/ready handshake at an auto-incrementing address.
module background_data_sequencer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address_i,
    input  logic              chipselect_i,
    input  logic              write_n_i,
    input  logic [31:0]       writedata_i,
    output logic [31:0]       readdata_o,
    input  logic              vblank_i,
    output logic              bg_wr_en_o,
    output logic [ADDR_W-1:0] bg_addr_o,
    output logic [31:0]       bg_data_o,
    input  logic              bg_ready_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         mem_q [DEPTH];
    logic [PtrW-1:0]     head_q, head_d;
    logic [PtrW-1:0]     tail_q, tail_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                enable_q, enable_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                bg_wr_en_q, bg_wr_en_d;
    logic [31:0]         bg_data_q, bg_data_d;

    logic        bus_wr;
    logic        sel_data, sel_ptr, sel_status, sel_ctrl;
    logic        flush, pop, push, full;
    logic [31:0] head_word;
    logic [31:0] status_word;

    assign bus_wr     = chipselect_i & ~write_n_i;
    assign sel_data   = bus_wr & (address_i == 2'd0);
    assign sel_ptr    = bus_wr & (address_i == 2'd1);
    assign sel_status = bus_wr & (address_i == 2'd2);
    assign sel_ctrl   = bus_wr & (address_i == 2'd3);
    assign flush      = sel_ctrl & writedata_i[1];
    assign pop        = bg_wr_en_q & bg_ready_i;
    assign full       = (count_q == CntW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = sel_data & (~full | pop);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        enable_d   = enable_q;
        ptr_d      = ptr_q;
        bg_data_d  = bg_data_q;
        head_word  = '0;

        if (sel_ctrl) begin
            enable_d = writedata_i[0];
        end
        if (sel_status) begin
            ovf_d = 1'b0;
        end else if (sel_data && !push) begin
            ovf_d = 1'b1;
        end

        // A pending word owns the pointer; software cannot move it mid-handshake.
        if (pop) begin
            ptr_d = ptr_q + 1'b1;
        end else if (sel_ptr && !bg_wr_en_q) begin
            ptr_d = writedata_i[ADDR_W-1:0];
        end

        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CntW'(push) - CntW'(pop);

        unique case (state_q)
            StIdle: begin
                if (enable_q && (count_q != '0)) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (vblank_i) begin
                    state_d = StDrain;
                end else if (!enable_q) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (pop) begin
                    if (count_d == '0) begin
                        state_d = StIdle;
                    end else if (!vblank_i || !enable_q) begin
                        state_d = StArmed;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = StIdle;
        end

        // Bypass covers the word being pushed into the slot that becomes the new head.
        head_word = (push && (tail_q == head_d)) ? writedata_i : mem_q[head_d];
        if ((state_d == StDrain) && ((state_q != StDrain) || pop)) begin
            bg_data_d = head_word;
        end
        bg_wr_en_d = (state_d == StDrain);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= writedata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            enable_q   <= 1'b0;
            ptr_q      <= '0;
            bg_wr_en_q <= 1'b0;
            bg_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            enable_q   <= enable_d;
            ptr_q      <= ptr_d;
            bg_wr_en_q <= bg_wr_en_d;
            bg_data_q  <= bg_data_d;
        end
    end

    always_comb begin
        status_word        = '0;
        status_word[8:0]   = 9'(count_q);
        status_word[9]     = (count_q == '0);
        status_word[10]    = full;
        status_word[11]    = ovf_q;
        status_word[12]    = bg_wr_en_q;
        status_word[14:13] = state_q;
        unique case (address_i)
            2'd0:    readdata_o = '0;
            2'd1:    readdata_o = 32'(ptr_q);
            2'd2:    readdata_o = status_word;
            default: readdata_o = {31'b0, enable_q};
        endcase
    end

    assign bg_wr_en_o = bg_wr_en_q;
    assign bg_addr_o  = ptr_q;
    assign bg_data_o  = bg_data_q;

endmodule

// File: tb/tb_background_data_sequencer.sv
// Randomised and directed bench: a queue-based reference model predicts tile writes into a
// scoreboard that a negedge monitor checks, together with bg_wr_en and every bus read.
module tb_background_data_sequencer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 11;
    localparam int          MASK   = (1 << ADDR_W) - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic [1:0]        addr;
    logic              cs;
    logic              wn;
    logic [31:0]       wdata;
    logic [31:0]       readdata;
    logic              vblank;
    logic              bg_wr_en;
    logic [ADDR_W-1:0] bg_addr;
    logic [31:0]       bg_data;
    logic              ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_fifo[$];
    exp_t        exp_q[$];
    int          m_ptr;
    int          m_state;
    bit          m_en;
    bit          m_ovf;

    background_data_sequencer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address_i    (addr),
        .chipselect_i (cs),
        .write_n_i    (wn),
        .writedata_i  (wdata),
        .readdata_o   (readdata),
        .vblank_i     (vblank),
        .bg_wr_en_o   (bg_wr_en),
        .bg_addr_o    (bg_addr),
        .bg_data_o    (bg_data),
        .bg_ready_i   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        int sz;
        sz = m_fifo.size();
        case (a)
            2'd0:    return 32'h0;
            2'd1:    return 32'(m_ptr);
            2'd2:    return (32'(m_state) << 13) | (32'(m_state == 2) << 12) |
                            (32'(m_ovf) << 11) | (32'(sz == DEPTH) << 10) |
                            (32'(sz == 0) << 9) | 32'(sz);
            default: return 32'(m_en);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Reference model: advances on each clock edge from the rules of the register map.
    initial begin : model
        bit wr, hs, fl;
        int old_state, old_size, ns;
        bit old_en;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_fifo.delete();
                exp_q.delete();
                m_ptr = 0; m_state = 0; m_en = 0; m_ovf = 0;
            end else begin
                wr        = cs && !wn;
                hs        = (m_state == 2) && ready;
                fl        = wr && (addr == 2'd3) && wdata[1];
                old_state = m_state;
                old_en    = m_en;
                old_size  = m_fifo.size();
                if (hs) begin
                    void'(m_fifo.pop_front());
                    m_ptr = (m_ptr + 1) & MASK;
                end else if (wr && addr == 2'd1 && old_state != 2) begin
                    m_ptr = int'(wdata) & MASK;
                end
                if (wr && addr == 2'd0) begin
                    if (old_size < DEPTH || hs) m_fifo.push_back(wdata);
                    else m_ovf = 1;
                end
                if (wr && addr == 2'd2) m_ovf = 0;
                if (wr && addr == 2'd3) m_en = wdata[0];
                ns = old_state;
                case (old_state)
                    0: if (old_en && old_size > 0) ns = 1;
                    1: if (vblank) ns = 2; else if (!old_en) ns = 0;
                    default: if (hs) begin
                        if (m_fifo.size() == 0) ns = 0;
                        else if (!vblank || !old_en) ns = 1;
                        else ns = 2;
                    end
                endcase
                if (fl) begin
                    m_fifo.delete();
                    exp_q.delete();
                    ns = 0;
                end
                m_state = ns;
                if (ns == 2 && (old_state != 2 || hs))
                    exp_q.push_back('{a: ADDR_W'(m_ptr), d: m_fifo[0]});
            end
        end
    end

    // Monitor: scoreboard pop on handshake, word stability while pending, bus reads.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("bg_wr_en", 32'(bg_wr_en), 32'(m_state == 2));
                if (bg_wr_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tile_word: got %h/%h, want none pending", bg_addr, bg_data);
                    end else begin
                        e = exp_q[0];
                        chk("tile_addr", 32'(bg_addr), 32'(e.a));
                        chk("tile_data", bg_data, e.d);
                        if (ready) void'(exp_q.pop_front());
                    end
                end
                if (cs && wn) chk("readdata", readdata, model_rd(addr));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wn = 1'b0; addr = a; wdata = d;
        cyc();
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; wn = 1'b1; addr = a;
        @(negedge clk);
        d = readdata;
        cyc();
        cs = 1'b0;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (bg_wr_en !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (bg_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL wait_busy: got bg_wr_en=%b after %0d cycles, want 1", bg_wr_en, n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int r;
        reset_n = 1'b0; cs = 1'b1; wn = 1'b1; addr = 2'd2; wdata = '0;
        vblank = 1'b0; ready = 1'b0;
        #12;
        chk("reset_status", readdata, 32'h0000_0200);
        chk("reset_wr_en", 32'(bg_wr_en), 32'h0);
        chk("reset_addr", 32'(bg_addr), 32'h0);
        chk("reset_data", bg_data, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1; cs = 1'b0;

        // Burst of three words in one blanking period
        bus_wr(2'd3, 32'h1);
        bus_wr(2'd1, 32'h010);
        bus_wr(2'd0, 32'hAAAA_0001);
        bus_wr(2'd0, 32'hBBBB_0002);
        bus_wr(2'd0, 32'hCCCC_0003);
        vblank = 1'b1; ready = 1'b1;
        repeat (6) cyc();
        bus_rd(2'd1, d);
        chk("ptr_after_burst", d, 32'h013);
        bus_rd(2'd2, d);
        chk("status_after_burst", d, 32'h0000_0200);

        // Back-pressure, vblank falls with a word pending
        vblank = 1'b0; ready = 1'b0;
        bus_wr(2'd0, 32'h1111_1111);
        bus_wr(2'd0, 32'h2222_2222);
        cyc();
        vblank = 1'b1;
        wait_busy();
        cyc();
        vblank = 1'b0;
        repeat (3) cyc();
        chk("held_addr", 32'(bg_addr), 32'h013);
        chk("held_data", bg_data, 32'h1111_1111);
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        bus_rd(2'd2, d);
        chk("armed_code", (d >> 13) & 32'h3, 32'h1);
        vblank = 1'b1; ready = 1'b1;
        repeat (4) cyc();
        vblank = 1'b0;

        // Overflow with enable low
        bus_wr(2'd3, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) bus_wr(2'd0, 32'hF000_0000 + 32'(i));
        bus_rd(2'd2, d);
        chk("status_overflow", d, 32'h0000_0C08);
        bus_wr(2'd2, 32'h0);
        bus_rd(2'd2, d);
        chk("status_ovf_cleared", d, 32'h0000_0408);
        bus_wr(2'd3, 32'h2);
        bus_rd(2'd2, d);
        chk("status_flushed", d, 32'h0000_0200);

        // Pointer wrap
        bus_wr(2'd1, 32'h7FF);
        bus_wr(2'd3, 32'h1);
        bus_wr(2'd0, 32'h5555_0001);
        bus_wr(2'd0, 32'h5555_0002);
        vblank = 1'b1;
        repeat (5) cyc();
        vblank = 1'b0;
        bus_rd(2'd1, d);
        chk("ptr_wrapped", d, 32'h001);

        // Flush mid-handshake; PTR write while busy is ignored
        ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_wr(2'd0, 32'h7700_0000 + 32'(i));
        vblank = 1'b1;
        wait_busy();
        bus_wr(2'd1, 32'h123);
        bus_rd(2'd1, d);
        chk("ptr_write_ignored", d, 32'h001);
        bus_wr(2'd3, 32'h3);
        chk("flush_wr_en", 32'(bg_wr_en), 32'h0);
        bus_rd(2'd2, d);
        chk("status_after_flush", d, 32'h0000_0200);
        vblank = 1'b0;

        // Asynchronous reset mid-drain
        bus_wr(2'd0, 32'h9999_0001);
        bus_wr(2'd0, 32'h9999_0002);
        vblank = 1'b1;
        wait_busy();
        cs = 1'b1; wn = 1'b1; addr = 2'd2;
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_wr_en", 32'(bg_wr_en), 32'h0);
        chk("async_reset_status", readdata, 32'h0000_0200);
        @(posedge clk); #1;
        reset_n = 1'b1; cs = 1'b0; vblank = 1'b0;

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) vblank = ~vblank;
            ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            cs = 1'b0; wn = 1'b1; wdata = $urandom;
            if (r < 30) begin
                cs = 1'b1; wn = 1'b0; addr = 2'd0;
            end else if (r < 35) begin
                cs = 1'b1; wn = 1'b0; addr = 2'd1;
            end else if (r < 38) begin
                cs = 1'b1; wn = 1'b0; addr = 2'd2;
            end else if (r < 42) begin
                cs = 1'b1; wn = 1'b0; addr = 2'd3;
                wdata[0] = ($urandom_range(0, 4) != 0);
                wdata[1] = ($urandom_range(0, 3) == 0);
            end else if (r < 60) begin
                cs = 1'b1; addr = 2'($urandom_range(0, 3));
            end
            cyc();
        end
        cs = 1'b0; wn = 1'b1;

        // Drain whatever is left
        bus_wr(2'd3, 32'h1);
        vblank = 1'b1; ready = 1'b1;
        repeat (2 * DEPTH + 4) cyc();
        bus_rd(2'd2, d);
        chk("final_status", d, 32'h0000_0200);
        chk("leftover_words", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
